// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor slice.
// Contents: the 2-bit counter state encoding, the counter values used on
// reset and on BTB allocation, and the PC word-offset used for indexing.
package branch_predictor_pkg;

    // Per-entry 2-bit saturating counter states.
    typedef enum logic [1:0] {
        SNT = 2'b00,  // strongly not-taken
        WNT = 2'b01,  // weakly not-taken
        WT  = 2'b10,  // weakly taken
        ST  = 2'b11   // strongly taken
    } ctr_e;

    localparam ctr_e        CTR_RESET   = WNT;  // value after reset
    localparam ctr_e        CTR_ALLOC   = WT;   // value on a fresh allocation
    localparam int unsigned PC_WORD_OFS = 2;    // pc[1:0] is the byte offset

    // The upper half of the state space predicts taken.
    function automatic logic ctr_predicts_taken(input ctr_e c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Bus between the CPU pipeline and the branch predictor.
//   lookup_pc         fetch-stage PC (combinational lookup)
//   predict_taken     redirect fetch to predict_target
//   predict_target    predicted target, 0 when not predicting taken
//   upd_valid         a resolved conditional branch is presented this cycle
//   upd_pc            PC of the resolved branch
//   upd_taken         resolved outcome
//   upd_target        resolved taken target
//   upd_predicted     prediction that was issued for this branch
//   branch_count      resolved branches since reset
//   mispredict_count  resolved branches that were mispredicted
// master = CPU side, slave = predictor side.
interface branch_predictor_if;

    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_predicted;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_predicted,
        input  predict_taken, predict_target, branch_count, mispredict_count
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_predicted,
        output predict_taken, predict_target, branch_count, mispredict_count
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter next-state function (combinational).
//   cnt_i  current counter state
//   up_i   1 = count up (branch taken), 0 = count down (not taken)
//   cnt_o  next counter state, saturating at SNT and ST
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e cnt_i,
    input  logic up_i,
    output ctr_e cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (up_i) begin
            if (cnt_i != ST) begin
                cnt_o = ctr_e'(cnt_i + 2'd1);
            end
        end else begin
            if (cnt_i != SNT) begin
                cnt_o = ctr_e'(cnt_i - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped table of 2-bit saturating
// counters combined with a tagged branch-target buffer.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears every entry and statistic
//   bus    branch_predictor_if.slave: combinational lookup from lookup_pc,
//          training from the upd_* group at the clock edge, and the
//          branch/mispredict statistics.
// Lookup has no bypass from a same-cycle update; new state is visible on
// the cycle after the training edge.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 16
)
(
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bus
);

    localparam int unsigned IDX_BITS = $clog2(ENTRIES);
    localparam int unsigned TAG_BITS = 30 - IDX_BITS;
    localparam int unsigned IDX_LSB  = PC_WORD_OFS;
    localparam int unsigned TAG_LSB  = IDX_BITS + PC_WORD_OFS;

    if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
        $error("branch_predictor: ENTRIES must be a power of two >= 2");
    end

    // Table state
    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    ctr_e                ctr_q    [ENTRIES];

    logic [31:0] branch_count_q,     branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    // Byte-offset bits never participate in indexing or tagging.
    logic [3:0] unused_pc_lsbs;
    assign unused_pc_lsbs = {bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    // ---------------------------------------------------------------- lookup
    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_hit;
    logic                lk_taken;

    assign lk_idx   = bus.lookup_pc[IDX_LSB +: IDX_BITS];
    assign lk_tag   = bus.lookup_pc[31:TAG_LSB];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_predicts_taken(ctr_q[lk_idx]);

    assign bus.predict_taken  = lk_taken;
    assign bus.predict_target = lk_taken ? target_q[lk_idx] : '0;

    // ---------------------------------------------------------------- update
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    ctr_e                upd_ctr_sat;

    assign upd_idx = bus.upd_pc[IDX_LSB +: IDX_BITS];
    assign upd_tag = bus.upd_pc[31:TAG_LSB];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    sat_counter2 u_sat_counter2 (
        .cnt_i (ctr_q[upd_idx]),
        .up_i  (bus.upd_taken),
        .cnt_o (upd_ctr_sat)
    );

    // Single write port into the entry selected by upd_pc.
    logic                wr_en;
    logic [TAG_BITS-1:0] wr_tag_d;
    logic [31:0]         wr_target_d;
    ctr_e                wr_ctr_d;

    always_comb begin
        wr_en       = 1'b0;
        wr_tag_d    = tag_q[upd_idx];
        wr_target_d = target_q[upd_idx];
        wr_ctr_d    = ctr_q[upd_idx];
        if (bus.upd_valid) begin
            if (upd_hit) begin
                wr_en    = 1'b1;
                wr_ctr_d = upd_ctr_sat;
                if (bus.upd_taken) begin
                    wr_target_d = bus.upd_target;
                end
            end else if (bus.upd_taken) begin
                // Taken miss: allocate, evicting whatever aliased here.
                wr_en       = 1'b1;
                wr_tag_d    = upd_tag;
                wr_target_d = bus.upd_target;
                wr_ctr_d    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '{default: 1'b0};
            tag_q    <= '{default: '0};
            target_q <= '{default: '0};
            ctr_q    <= '{default: CTR_RESET};
        end else if (wr_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= wr_tag_d;
            target_q[upd_idx] <= wr_target_d;
            ctr_q[upd_idx]    <= wr_ctr_d;
        end
    end

    // ------------------------------------------------------------ statistics
    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bus.upd_valid) begin
            if (branch_count_q != '1) begin
                branch_count_d = branch_count_q + 32'd1;
            end
            if ((bus.upd_predicted != bus.upd_taken) && (mispredict_count_q != '1)) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic, scored against a behavioural model of the predictor.
module tb_branch_predictor;

    localparam int unsigned ENT = 16;

    logic clk;
    logic reset;

    branch_predictor_if bus_if ();

    branch_predictor #(.ENTRIES(ENT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ model
    bit              m_valid [ENT];
    int unsigned     m_tag   [ENT];
    logic [31:0]     m_tgt   [ENT];
    int              m_ctr   [ENT];
    longint unsigned m_bc, m_mc;

    localparam longint unsigned SAT32 = 64'hFFFF_FFFF;

    function automatic int unsigned pc_idx(input logic [31:0] pc);
        return (pc / 4) % ENT;
    endfunction

    function automatic int unsigned pc_tag(input logic [31:0] pc);
        return pc / (4 * ENT);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
        int unsigned i;
        i   = pc_idx(pc);
        pt  = m_valid[i] && (m_tag[i] == pc_tag(pc)) && (m_ctr[i] >= 2);
        tgt = pt ? m_tgt[i] : 32'h0;
    endtask

    task automatic model_update(input logic uv, input logic [31:0] pc, input logic t,
                                input logic [31:0] tgt, input logic pred);
        int unsigned i;
        if (!uv) return;
        i = pc_idx(pc);
        if (m_bc < SAT32) m_bc++;
        if ((pred != t) && (m_mc < SAT32)) m_mc++;
        if (m_valid[i] && (m_tag[i] == pc_tag(pc))) begin
            if (t) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (t) begin
            m_valid[i] = 1;
            m_tag[i]   = pc_tag(pc);
            m_tgt[i]   = tgt;
            m_ctr[i]   = 2;
        end
    endtask

    // ------------------------------------------------------- scoreboard
    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] tgt;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   errors = 0;
    int   checks = 0;

    task automatic push_expect(input string name, input logic [31:0] lpc);
        exp_t e;
        e.name = name;
        model_lookup(lpc, e.pt, e.tgt);
        e.bc = m_bc[31:0];
        e.mc = m_mc[31:0];
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per presented sample and compares.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got empty queue expected an entry");
            end else begin
                e = sb_q.pop_front();
                chk({e.name, ".predict_taken"},    {31'b0, bus_if.predict_taken}, {31'b0, e.pt});
                chk({e.name, ".predict_target"},   bus_if.predict_target,   e.tgt);
                chk({e.name, ".branch_count"},     bus_if.branch_count,     e.bc);
                chk({e.name, ".mispredict_count"}, bus_if.mispredict_count, e.mc);
            end
        end
    end

    // One cycle: drive lookup + optional update after the edge, record the
    // expected lookup (pre-update state), sample mid-cycle, then advance
    // the model to what the next edge will commit.
    task automatic step(input string name, input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic t, input logic [31:0] tgt,
                        input logic pred);
        @(posedge clk);
        #1;
        bus_if.lookup_pc     = lpc;
        bus_if.upd_valid     = uv;
        bus_if.upd_pc        = upc;
        bus_if.upd_taken     = t;
        bus_if.upd_target    = tgt;
        bus_if.upd_predicted = pred;
        push_expect(name, lpc);
        #2;
        ->sample_ev;
        if (!reset) model_update(uv, upc, t, tgt, pred);
    endtask

    task automatic look(input string name, input logic [31:0] lpc);
        step(name, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input string name, input logic [31:0] upc, input logic t,
                       input logic [31:0] tgt, input logic pred);
        step(name, upc, 1'b1, upc, t, tgt, pred);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        rp;
        logic [31:0] rt;
        logic [31:0] rpc;
        logic        ruv, rtk, rpred;

        reset = 1'b1;
        bus_if.lookup_pc     = '0;
        bus_if.upd_valid     = 1'b0;
        bus_if.upd_pc        = '0;
        bus_if.upd_taken     = 1'b0;
        bus_if.upd_target    = '0;
        bus_if.upd_predicted = 1'b0;
        model_reset();

        // 1: reset state
        look("t1_rst_0x10", 32'h10);
        look("t1_rst_0x100", 32'h100);
        #2 reset = 1'b0;
        look("t1_post_0x10", 32'h10);

        // 2: allocate on a taken miss
        upd("t2_alloc", 32'h10, 1'b1, 32'h40, 1'b0);
        look("t2_hit", 32'h10);

        // 3: down-count and saturation at SNT
        upd("t3_nt1", 32'h10, 1'b0, 32'h0, 1'b1);
        look("t3_after_nt1", 32'h10);
        upd("t3_nt2", 32'h10, 1'b0, 32'h0, 1'b0);
        look("t3_after_nt2", 32'h10);
        upd("t3_nt3", 32'h10, 1'b0, 32'h0, 1'b0);
        look("t3_after_nt3", 32'h10);

        // 4: aliasing on index 4
        upd("t4_train10", 32'h10, 1'b1, 32'h44, 1'b0);
        upd("t4_train10b", 32'h10, 1'b1, 32'h44, 1'b0);
        look("t4_10_trained", 32'h10);
        upd("t4_alias50", 32'h50, 1'b1, 32'h80, 1'b1);
        look("t4_10_evicted", 32'h10);
        look("t4_50_hit", 32'h50);
        look("t4_lsb_ignored", 32'h53);

        // 5: same-cycle lookup and update, no bypass
        upd("t5_same_cycle", 32'h20, 1'b1, 32'h0C, 1'b0);
        look("t5_next_cycle", 32'h20);
        upd("t5_up_sat1", 32'h20, 1'b1, 32'h0C, 1'b1);
        upd("t5_up_sat2", 32'h20, 1'b1, 32'h1C, 1'b1);
        look("t5_target_overwritten", 32'h20);
        upd("t5_down_from_st", 32'h20, 1'b0, 32'h0, 1'b1);
        look("t5_still_taken", 32'h20);

        // 6: asynchronous reset pulse between edges
        upd("t6_train_a", 32'h30, 1'b1, 32'hA0, 1'b0);
        look("t6_pre_reset", 32'h50);
        #1 reset = 1'b1;
        model_reset();
        #1;
        push_expect("t6_in_reset", 32'h50);
        ->sample_ev;
        #1 reset = 1'b0;
        look("t6_after_50", 32'h50);
        look("t6_after_30", 32'h30);
        look("t6_after_20", 32'h20);

        // Randomized traffic over a small PC pool so hits and aliases occur
        for (int n = 0; n < 400; n++) begin
            rpc = ($urandom_range(0, 47) * 4) | $urandom_range(0, 3);
            ruv = ($urandom_range(0, 3) != 0);
            rtk = $urandom_range(0, 1);
            model_lookup(rpc, rp, rt);
            rpred = ($urandom_range(0, 3) == 0) ? ~rp : rp;
            step("rnd", ($urandom_range(0, 1) != 0) ? rpc : ($urandom_range(0, 47) * 4),
                 ruv, rpc, rtk, $urandom(), rpred);
        end
        look("final_idle", 32'h10);

        #5;
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor feeding the control unit's predict_taken decision and the fetch stage's next-PC selection.
- Structure: direct-mapped table of 2-bit saturating counters, combined with a tagged branch-target buffer (BTB).
- Lookup: combinational, from the fetch PC.
- Training: by the resolved branch outcome from execute, one cycle later.
- Keeps branch and mispredict statistics that the CPU testbench reads hierarchically.

Parameters:
- ENTRIES, 16: number of table entries; power of two, minimum 2.
- IDX_BITS, $clog2(ENTRIES): index width; derived, never overridden.
- TAG_BITS, 30-IDX_BITS: stored tag width (pc[31:IDX_BITS+2]).

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- lookup_pc  in  32  fetch-stage PC (word aligned).
- predict_taken  out  1  1 = fetch should redirect to predict_target.
- predict_target  out  32  predicted target; 0 when predict_taken=0.
- upd_valid  in  1  a resolved conditional branch is presented this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  actual taken target.
- upd_predicted  in  1  predict_taken value that was issued for this branch.
- branch_count  out  32  resolved branches since reset.
- mispredict_count  out  32  resolved branches with upd_predicted != upd_taken.

Behaviour:
- Reset (asynchronous, takes effect immediately mid-operation):
  - Every entry: valid=0, tag=0, target=0, counter=2'b01 (weakly not-taken).
  - Both statistics counters cleared to 0.
  - predict_taken=0 and predict_target=0 while reset is high and after release until trained.
- Indexing: idx = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]; pc[1:0] ignored.
- Lookup (0-cycle latency, purely combinational from lookup_pc and table state):
  - hit = valid[idx] && tag[idx]==lookup tag.
  - predict_taken = hit && counter[idx][1].
  - predict_target = predict_taken ? target[idx] : 0.
- Update (registered at the rising clk edge when upd_valid=1):
  - Tag match, taken: counter = min(3, c+1); target overwritten with upd_target.
  - Tag match, not taken: counter = max(0, c-1); target unchanged.
  - Miss, taken: allocate (replace any existing entry). valid=1, tag=upd tag, target=upd_target, counter=2'b10.
  - Miss, not taken: no table change.
  - branch_count += 1.
  - mispredict_count += 1 iff upd_predicted != upd_taken.
  - Both counters saturate at 32'hFFFFFFFF; no wrap to 0.
- upd_valid=0: no state change; upd_* inputs ignored.
- Simultaneous lookup and update, same index:
  - No bypass. The lookup in that cycle reflects pre-update state.
  - The new state is visible from the next cycle.
- Only one update per cycle. No backpressure; the block always accepts.
- No FSM beyond per-entry counter states:
  - SNT(00) and WNT(01) predict not-taken.
  - WT(10) and ST(11) predict taken.
  - Transitions are ±1 with saturation, per the update rules.

Decomposition:
- Shared package:
  - Counter encodings SNT/WNT/WT/ST.
  - Reset counter value (WNT) and allocation counter value (WT).
  - PC word-offset constant (2).
- Natural sub-module: sat_counter2, a 2-bit saturating up/down next-state function. Instantiated per update path; may be combinational.
- Table storage stays in branch_predictor as register arrays, since asynchronous reset of all entries is required.

Test Plan:
1. Reset, then look up 0x10 and 0x100. Expect predict_taken=0, predict_target=0, branch_count=0, mispredict_count=0.
2. Update pc=0x10, taken=1, target=0x40, predicted=0. Next cycle, look up 0x10. Expect predict_taken=1, predict_target=0x40, branch_count=1, mispredict_count=1.
3. Two further not-taken updates at 0x10 (predicted=1, then 0). Expect a prediction of 0 after the first (counter 1) and 0 after the second (counter 0). A third not-taken update keeps counter 0. Final mispredict_count=2, branch_count=4.
4. Alias with ENTRIES=16: train 0x10 taken, then update 0x50 taken with target 0x80 (same idx 4). Expect lookup 0x10 to give predict_taken=0 (tag miss) and lookup 0x50 to give predict_taken=1, target 0x80.
5. Same cycle: lookup 0x20 together with first taken update at 0x20 (target 0x0C). Expect predict_taken=0 that cycle and predict_taken=1, target 0x0C the next cycle.
6. After training several entries, pulse reset between clock edges. Expect all outputs to return to 0 before the next edge and lookups to miss after release.
